// File: rtl/memory_game_pkg.sv
// Shared constants for the memory game: state encoding, LFSR setup and
// the fallback pattern used when the LFSR snapshot is all zeros.
package memory_game_pkg;

    // One-hot state encoding; bit order matches {Ql, Qfo, Qg, Qp, Qi}
    localparam logic [4:0] ST_INIT    = 5'b00001;
    localparam logic [4:0] ST_PREVIEW = 5'b00010;
    localparam logic [4:0] ST_GUESS   = 5'b00100;
    localparam logic [4:0] ST_FAIL    = 5'b01000;
    localparam logic [4:0] ST_CLEAR   = 5'b10000;

    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam logic [15:0] FALLBACK_PATTERN = 16'hA5A5;

    // Tile (row, col) lives at bit row*4+col of the 16-bit board
    function automatic logic [3:0] tile_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every cycle.
module lfsr16
    import memory_game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    // Shift left, feeding back the parity of the tapped bits
    always_comb begin
        q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end

    // State register, reseeded on reset
    always_ff @(posedge clk) begin
        if (rst) q_q <= LFSR_SEED;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/memory_game_sm.sv
// Memory game controller: preview a random 4x4 pattern, then let the
// player reveal tiles with a cursor until the pattern is found or the
// miss budget is spent. All outputs come straight from flops.
module memory_game_sm
    import memory_game_pkg::*;
#(
    parameter int PREVIEW_CYCLES = 100_000_000,
    parameter int MAX_MISSES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       sel,
    output logic [1:0] X,
    output logic [1:0] Y,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] B0,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic       Qi,
    output logic       Qp,
    output logic       Qg,
    output logic       Qfo,
    output logic       Ql,
    output logic [1:0] misses
);

    localparam int CW = (PREVIEW_CYCLES > 1) ? $clog2(PREVIEW_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PREVIEW_CYCLES - 1);

    logic [15:0]   lfsr_val;
    logic [4:0]    state_q, state_d;
    logic [15:0]   pattern_q, pattern_d;
    logic [15:0]   mask_q, mask_d;
    logic [15:0]   disp_q, disp_d;
    logic [1:0]    x_q, x_d, y_q, y_d;
    logic [1:0]    misses_q, misses_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    // Next-state, board and cursor update
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        x_d       = x_q;
        y_d       = y_q;
        misses_d  = misses_q;
        cnt_d     = cnt_q;
        idx       = tile_idx(x_q, y_q);
        case (state_q)
            ST_INIT: begin
                if (start) begin
                    pattern_d = (lfsr_val == '0) ? FALLBACK_PATTERN : lfsr_val;
                    mask_d    = '0;
                    misses_d  = '0;
                    x_d       = '0;
                    y_d       = '0;
                    cnt_d     = '0;
                    state_d   = ST_PREVIEW;
                end
            end
            ST_PREVIEW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_GUESS;
            end
            ST_GUESS: begin
                if (sel) begin
                    // Guess wins over movement; revealed tiles are inert
                    if (!mask_q[idx]) begin
                        mask_d[idx] = 1'b1;
                        if (!pattern_q[idx]) begin
                            misses_d = misses_q + 1'b1;
                            if (misses_d == 2'(MAX_MISSES)) state_d = ST_FAIL;
                        end else if ((mask_d & pattern_q) == pattern_q) begin
                            state_d = ST_CLEAR;
                        end
                    end
                end else begin
                    // Opposing pulses on one axis cancel; 2-bit wrap is free
                    if (up && !down)    x_d = x_q - 1'b1;
                    if (down && !up)    x_d = x_q + 1'b1;
                    if (left && !right) y_d = y_q - 1'b1;
                    if (right && !left) y_d = y_q + 1'b1;
                end
            end
            ST_FAIL, ST_CLEAR: begin
                if (start) state_d = ST_INIT;
            end
            default: state_d = ST_INIT;
        endcase
        // Display follows the state being entered so B stays registered
        disp_d = (state_d == ST_PREVIEW) ? pattern_d : mask_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            pattern_q <= '0;
            mask_q    <= '0;
            disp_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            misses_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            disp_q    <= disp_d;
            x_q       <= x_d;
            y_q       <= y_d;
            misses_q  <= misses_d;
            cnt_q     <= cnt_d;
        end
    end

    assign X      = x_q;
    assign Y      = y_q;
    assign {A3, A2, A1, A0} = pattern_q;
    assign {B3, B2, B1, B0} = disp_q;
    assign {Ql, Qfo, Qg, Qp, Qi} = state_q;
    assign misses = misses_q;

endmodule
